// File: rtl/dm_responder.sv
// MEM-stage data-memory responder: one valid/ready request at a time, fixed wait
// states, MIPS byte/half/word lane selection, load extension and error reporting.
module dm_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORDS  = 1 << (ADDR_W - 2);

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               accept_c;
  req_t               req_q, cur_c;
  logic [DATA_W-1:0]  mem [WORDS];
  logic [DATA_W-1:0]  word_c, rdata_c, wmask_c, wword_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;
  logic               err_c;
  logic [3:0]         be_c;

  // Next-state and wait counter
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_n = S_WAIT;
            cnt_n   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_n = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_n = S_RESP;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge, so read the live request
  assign cur_c = (state == S_IDLE) ? {req_we, req_op, req_addr, req_wdata} : req_q;

  // Lane selection, load extension and error decode
  always_comb begin
    word_c = mem[cur_c.addr[ADDR_W-1:2]];
    case (cur_c.addr[1:0])
      2'd0:    byte_c = word_c[7:0];
      2'd1:    byte_c = word_c[15:8];
      2'd2:    byte_c = word_c[23:16];
      default: byte_c = word_c[31:24];
    endcase
    half_c  = cur_c.addr[1] ? word_c[31:16] : word_c[15:0];
    err_c   = 1'b0;
    rdata_c = '0;
    case (cur_c.op)
      OP_LB:  begin err_c = cur_c.we; rdata_c = {{24{byte_c[7]}}, byte_c}; end
      OP_LBU: begin err_c = cur_c.we; rdata_c = {24'd0, byte_c}; end
      OP_LH:  begin err_c = cur_c.we | cur_c.addr[0]; rdata_c = {{16{half_c[15]}}, half_c}; end
      OP_LHU: begin err_c = cur_c.we | cur_c.addr[0]; rdata_c = {16'd0, half_c}; end
      OP_LW:  begin err_c = cur_c.we | (cur_c.addr[1:0] != 2'b00); rdata_c = word_c; end
      OP_SB:  err_c = ~cur_c.we;
      OP_SH:  err_c = ~cur_c.we | cur_c.addr[0];
      OP_SW:  err_c = ~cur_c.we | (cur_c.addr[1:0] != 2'b00);
      default: err_c = 1'b1;
    endcase
    if (err_c) rdata_c = '0;
  end

  // Store lane merge from the latched request
  always_comb begin
    case (req_q.op)
      OP_SB: begin
        be_c    = 4'b0001 << req_q.addr[1:0];
        wword_c = {4{req_q.wdata[7:0]}};
      end
      OP_SH: begin
        be_c    = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wword_c = {2{req_q.wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wword_c = req_q.wdata;
      end
    endcase
    wmask_c = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
  end

  // Commit at the edge ending RESP; an error or a reset on that edge suppresses it
  always_ff @(posedge clk) begin
    if (rst && state == S_RESP && req_q.we && !resp_err) begin
      mem[req_q.addr[ADDR_W-1:2]] <= (mem[req_q.addr[ADDR_W-1:2]] & ~wmask_c) | (wword_c & wmask_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      req_ready  <= (state_n == S_IDLE);
      resp_valid <= (state_n == S_RESP);
      if (accept_c) req_q <= cur_c;
      if (state_n == S_RESP) begin
        resp_rdata <= rdata_c;
        resp_err   <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a 2-wait-state instance and a zero-wait instance,
// checked against a word-array memory model with directed and random traffic.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b;
  logic        req_we;
  logic [5:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rv_a, rv_b;
  logic [31:0] rd_a, rd_b;
  logic        er_a, er_b;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [2][1024];

  typedef struct {
    logic        we;
    logic [5:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;

  always #5 clk = ~clk;

  dm_responder #(.WAIT_CYCLES(2), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(er_a)
  );

  dm_responder #(.WAIT_CYCLES(0), .ADDR_W(12)) dut0 (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(er_b)
  );

  // Reference: memory as whole words, results from the opcode rules directly
  function automatic void model_txn(input int b, input logic we, input logic [5:0] op,
                                    input logic [11:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic er);
    logic [31:0] w;
    logic [7:0]  by;
    logic [15:0] hw;
    int lane, hsel;
    w    = mdl[b][addr[11:2]];
    lane = int'(addr[1:0]);
    hsel = int'(addr[1]);
    by   = 8'(w >> (8 * lane));
    hw   = 16'(w >> (16 * hsel));
    er   = 1'b1;
    rd   = 32'd0;
    case (op)
      6'h20: if (!we) begin er = 1'b0; rd = 32'($signed(by)); end
      6'h24: if (!we) begin er = 1'b0; rd = 32'(by); end
      6'h21: if (!we && !addr[0]) begin er = 1'b0; rd = 32'($signed(hw)); end
      6'h25: if (!we && !addr[0]) begin er = 1'b0; rd = 32'(hw); end
      6'h23: if (!we && addr[1:0] == 2'b00) begin er = 1'b0; rd = w; end
      6'h28: if (we) begin er = 1'b0; w[8*lane +: 8] = wd[7:0]; end
      6'h29: if (we && !addr[0]) begin er = 1'b0; w[16*hsel +: 16] = wd[15:0]; end
      6'h2B: if (we && addr[1:0] == 2'b00) begin er = 1'b0; w = wd; end
      default: ;
    endcase
    mdl[b][addr[11:2]] = w;
  endfunction

  function automatic logic [5:0] pick_op(input int i);
    case (i)
      0: return 6'h20; 1: return 6'h24; 2: return 6'h21; 3: return 6'h25;
      4: return 6'h23; 5: return 6'h28; 6: return 6'h29; 7: return 6'h2B;
      default: return 6'h3F;
    endcase
  endfunction

  task automatic rand_req(input int amax, output logic we, output logic [5:0] op,
                          output logic [11:0] addr, output logic [31:0] wd);
    op   = pick_op(int'($urandom_range(0, 8)));
    we   = op[3];
    if ($urandom_range(0, 9) == 0) we = ~we;
    addr = 12'($urandom_range(0, amax));
    wd   = $urandom;
  endtask

  // Drive one request on instance b (0 = wait-2, 1 = zero-wait); lat=0 means no response
  task automatic run(input int b, input logic we, input logic [5:0] op, input logic [11:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    if (b == 1) valid_b = 1'b1; else valid_a = 1'b1;
    guard = 0;
    while (!((b == 1) ? ready_b : ready_a) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    lat = 0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((b == 1) ? rv_b : rv_a) begin
        lat = k;
        rd  = (b == 1) ? rd_b : rd_a;
        er  = (b == 1) ? er_b : er_a;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    req_we = 1'b0; req_op = 6'h23; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({ready_a, ready_b} !== 2'b11) begin n_err++; $display("FAIL reset_ready: got %b expected 11", {ready_a, ready_b}); end
    n_vec++; if ({rv_a, rv_b} !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b expected 00", {rv_a, rv_b}); end
    n_vec++; if (rd_a !== 32'd0 || rd_b !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h/%h expected 0", rd_a, rd_b); end
    n_vec++; if ({er_a, er_b} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b expected 00", {er_a, er_b}); end
  endtask

  task automatic test_init();
    logic [31:0] rd, erd, wd;
    logic er, eer;
    int lat;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        model_txn(b, 1'b1, 6'h2B, 12'(4 * i), wd, erd, eer);
        run(b, 1'b1, 6'h2B, 12'(4 * i), wd, rd, er, lat);
        n_vec++;
        if (er !== 1'b0 || rd !== 32'd0 || lat != ((b == 1) ? 1 : 3)) begin
          n_err++;
          $display("FAIL init_sw[%0d][%0d]: got err=%b rd=%h lat=%0d expected err=0 rd=0 lat=%0d", b, i, er, rd, lat, (b == 1) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_lanes();
    vec_t tbl[$];
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat;
    tbl.push_back('{1'b1, 6'h2B, 12'h010, 32'h12345678, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 6'h23, 12'h010, 32'h0, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 6'h20, 12'h013, 32'h0, 32'h00000012, 1'b0});
    tbl.push_back('{1'b0, 6'h25, 12'h012, 32'h0, 32'h00001234, 1'b0});
    tbl.push_back('{1'b1, 6'h29, 12'h010, 32'h00008001, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 6'h21, 12'h010, 32'h0, 32'hFFFF8001, 1'b0});
    tbl.push_back('{1'b1, 6'h2B, 12'h010, 32'h12345678, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 6'h28, 12'h011, 32'h00000080, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 6'h23, 12'h010, 32'h0, 32'h12348078, 1'b0});
    tbl.push_back('{1'b0, 6'h20, 12'h011, 32'h0, 32'hFFFFFF80, 1'b0});
    tbl.push_back('{1'b0, 6'h24, 12'h011, 32'h0, 32'h00000080, 1'b0});
    tbl.push_back('{1'b0, 6'h23, 12'h006, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 6'h29, 12'h011, 32'h0000ABCD, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 6'h23, 12'h010, 32'h0, 32'h12348078, 1'b0});
    tbl.push_back('{1'b1, 6'h23, 12'h010, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 6'h2B, 12'h010, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 6'h3F, 12'h010, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 6'h28, 12'h013, 32'h0, 32'h0, 1'b1} );
    tbl[17].we = 1'b0;
    tbl.push_back('{1'b0, 6'h23, 12'h010, 32'h0, 32'h12348078, 1'b0});
    foreach (tbl[i]) begin
      model_txn(0, tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wd, mrd, mer);
      run(0, tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wd, rd, er, lat);
      n_vec++;
      if (rd !== tbl[i].rd || er !== tbl[i].er || lat != 3) begin
        n_err++;
        $display("FAIL lanes[%0d] op=%h addr=%h: got rd=%h err=%b lat=%0d expected rd=%h err=%b lat=3",
                 i, tbl[i].op, tbl[i].addr, rd, er, lat, tbl[i].rd, tbl[i].er);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, seen;
    @(negedge clk);
    req_we = 1'b1; req_op = 6'h2B; req_addr = 12'h020; req_wdata = 32'hDEADBEEF;
    valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    seen = int'(rv_a);
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b expected 1", ready_a); end
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen += int'(rv_a);
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL abort_no_resp: got %0d responses expected 0", seen); end
    model_txn(0, 1'b0, 6'h23, 12'h020, 32'h0, erd, eer);
    run(0, 1'b0, 6'h23, 12'h020, 32'h0, rd, er, lat);
    n_vec++;
    if (rd !== erd || er !== 1'b0 || lat != 3) begin
      n_err++;
      $display("FAIL abort_old_value: got rd=%h err=%b lat=%0d expected rd=%h err=0 lat=3", rd, er, lat, erd);
    end
  endtask

  // Requester holds valid high and changes the request every cycle
  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    logic we;
    logic [5:0] op;
    logic [11:0] addr;
    logic [31:0] wd;
    int accepts = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (rv_a) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_spurious: got response at cycle %0d expected none", c);
        end else begin
          e = q.pop_front();
          if (rd_a !== e.rd || er_a !== e.er || c - e.cyc != 3) begin
            n_err++;
            $display("FAIL b2b_resp: got rd=%h err=%b lat=%0d expected rd=%h err=%b lat=3", rd_a, er_a, c - e.cyc, e.rd, e.er);
          end
        end
      end
      if (c < 60) begin
        rand_req(63, we, op, addr, wd);
        req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
        valid_a = 1'b1;
        if (ready_a) begin
          model_txn(0, we, op, addr, wd, e.rd, e.er);
          e.cyc = c;
          q.push_back(e);
          accepts++;
        end
      end else begin
        valid_a = 1'b0;
      end
    end
    n_vec++;
    if (q.size() != 0 || accepts != 15) begin
      n_err++;
      $display("FAIL b2b_count: got %0d pending, %0d accepts expected 0 pending, 15 accepts", q.size(), accepts);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd, erd;
    logic er, eer;
    logic we;
    logic [5:0] op;
    logic [11:0] addr;
    logic [31:0] wd;
    int lat;
    model_txn(1, 1'b1, 6'h2B, 12'h010, 32'h12345678, erd, eer);
    run(1, 1'b1, 6'h2B, 12'h010, 32'h12345678, rd, er, lat);
    n_vec++; if (er !== 1'b0 || lat != 1) begin n_err++; $display("FAIL zw_sw: got err=%b lat=%0d expected err=0 lat=1", er, lat); end
    model_txn(1, 1'b0, 6'h23, 12'h010, 32'h0, erd, eer);
    run(1, 1'b0, 6'h23, 12'h010, 32'h0, rd, er, lat);
    n_vec++;
    if (rd !== 32'h12345678 || er !== 1'b0 || lat != 1) begin
      n_err++;
      $display("FAIL zw_lw: got rd=%h err=%b lat=%0d expected rd=12345678 err=0 lat=1", rd, er, lat);
    end
    for (int i = 0; i < 30; i++) begin
      rand_req(63, we, op, addr, wd);
      model_txn(1, we, op, addr, wd, erd, eer);
      run(1, we, op, addr, wd, rd, er, lat);
      n_vec++;
      if (rd !== erd || er !== eer || lat != 1) begin
        n_err++;
        $display("FAIL zw_rand[%0d] op=%h we=%b addr=%h: got rd=%h err=%b lat=%0d expected rd=%h err=%b lat=1",
                 i, op, we, addr, rd, er, lat, erd, eer);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_lanes();
    test_reset_abort();
    test_back_to_back();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
